// File: rtl/csla_ripple_block.sv
// rtl/csla_ripple_block.sv - SIZE-bit ripple-carry adder used as one carry-select block
module csla_ripple_block #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);

  logic [SIZE:0] c;

  // Carries are kept in a local chain so each bit is a plain full adder.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int k = 0; k < SIZE; k++) begin
      sum[k]  = a[k] ^ b[k] ^ c[k];
      c[k+1]  = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
    end
    cout = c[SIZE];
  end

endmodule

// File: rtl/carry_select_adder.sv
// rtl/carry_select_adder.sv - N-bit carry-select adder with registered sum and carry-out
module carry_select_adder #(
  parameter int N    = 32,
  parameter int SIZE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int NUM_BLOCKS = (SIZE >= 1) ? (N / SIZE) : 1;

  generate
    if (N < 1 || SIZE < 1 || (N % SIZE) != 0) begin : g_param_check
      $error("carry_select_adder: N must be >= 1 and an integer multiple of SIZE >= 1");
    end
  endgenerate

  logic [N-1:0] sum_comb;

  // Each block exposes its selected carry-out as g_blk[i].co so the next block can pick its sum.
  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
    logic co;

    if (i == 0) begin : g_first
      csla_ripple_block #(.SIZE(SIZE)) u_ripple (
        .a    (a[0 +: SIZE]),
        .b    (b[0 +: SIZE]),
        .cin  (cin),
        .sum  (sum_comb[0 +: SIZE]),
        .cout (co)
      );
    end else begin : g_select
      logic [SIZE-1:0] sum0;
      logic [SIZE-1:0] sum1;
      logic            co0;
      logic            co1;
      logic            sel;

      assign sel = g_blk[i-1].co;

      csla_ripple_block #(.SIZE(SIZE)) u_ripple0 (
        .a    (a[i*SIZE +: SIZE]),
        .b    (b[i*SIZE +: SIZE]),
        .cin  (1'b0),
        .sum  (sum0),
        .cout (co0)
      );

      csla_ripple_block #(.SIZE(SIZE)) u_ripple1 (
        .a    (a[i*SIZE +: SIZE]),
        .b    (b[i*SIZE +: SIZE]),
        .cin  (1'b1),
        .sum  (sum1),
        .cout (co1)
      );

      assign sum_comb[i*SIZE +: SIZE] = sel ? sum1 : sum0;
      assign co                        = sel ? co1  : co0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_comb;
      cout <= g_blk[NUM_BLOCKS-1].co;
    end
  end

endmodule

// File: tb/tb_carry_select_adder.sv
// tb/tb_carry_select_adder.sv - random and directed checks of carry_select_adder in three configurations
module tb_carry_select_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        cin32 = 1'b0, cout32;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        cin8 = 1'b0, cout8;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cin16 = 1'b0, cout16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  carry_select_adder #(.N(32), .SIZE(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .cin(cin32), .sum(sum32), .cout(cout32)
  );
  carry_select_adder #(.N(8), .SIZE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8)
  );
  carry_select_adder #(.N(16), .SIZE(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16), .sum(sum16), .cout(cout16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain wide integer addition, truncated to N+1 bits.
  function automatic logic [63:0] ref_add(input int n, input longint unsigned x,
                                          input longint unsigned y, input logic ci);
    longint unsigned s;
    s = x + y + longint'(ci);
    return s & ((64'd1 << (n + 1)) - 64'd1);
  endfunction

  task automatic step32(input string tag, input logic r, input logic [31:0] x,
                        input logic [31:0] y, input logic ci, input logic [32:0] exp);
    rst_n = r; a32 = x; b32 = y; cin32 = ci;
    @(posedge clk);
    #1;
    check(tag, {31'd0, cout32, sum32}, {31'd0, exp});
  endtask

  initial begin
    logic [63:0] e32, e8, e16;

    // Reset state
    @(posedge clk);
    #1;
    check("reset32", {31'd0, cout32, sum32}, 64'd0);
    check("reset8",  {55'd0, cout8, sum8},   64'd0);
    check("reset16", {47'd0, cout16, sum16}, 64'd0);

    // Reset holds outputs low even with saturating operands
    step32("rst_hold0", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h0);
    step32("rst_hold1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h0);
    step32("rst_release", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF);

    // Directed vectors
    step32("basic",      1'b1, 32'h00000003, 32'h0000000A, 1'b0, 33'h0_0000000D);
    step32("alt_cin0",   1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b0, 33'h0_FFFFFFFF);
    step32("alt_cin1",   1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b1, 33'h1_00000000);
    step32("wrap_b1",    1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_00000000);
    step32("wrap_cin",   1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000);
    step32("pattern",    1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 33'h0_FFFFFFFF);
    step32("msb_carry",  1'b1, 32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000);

    // Mid-stream reset discards the in-flight result, next result follows normally
    step32("mid_pre",    1'b1, 32'h12345678, 32'h11111111, 1'b0, 33'h0_23456789);
    step32("mid_rst",    1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h0);
    step32("mid_post",   1'b1, 32'h0000FFFF, 32'h00000001, 1'b1, 33'h0_00010001);

    // Back-to-back random vectors on all three configurations
    for (int k = 0; k < 1200; k++) begin
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
      a8  = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      if (k % 16 == 0) begin
        a32 = 32'hFFFFFFFF; b32 = 32'($urandom_range(0, 1));
        a8  = 8'hFF;        b8  = 8'($urandom_range(0, 1));
        a16 = 16'hFFFF;     b16 = 16'($urandom_range(0, 1));
      end
      e32 = ref_add(32, 64'(a32), 64'(b32), cin32);
      e8  = ref_add(8,  64'(a8),  64'(b8),  cin8);
      e16 = ref_add(16, 64'(a16), 64'(b16), cin16);
      @(posedge clk);
      #1;
      check("rand32", {31'd0, cout32, sum32}, e32);
      check("rand8",  {55'd0, cout8, sum8},   e8);
      check("rand16", {47'd0, cout16, sum16}, e16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
